stream_hub: RTL

- Parametrised successor to the single-path SPI→FIFO→compute→UART datapath.
- Accepts NUM_CH independent word streams, buffers each in its own FIFO, and assembles fixed-length packets of PKT_LEN words.
- Dispatches packets to one downstream packet consumer (UART/softmax-style tx_data/valid/done handshake), with round-robin arbitration and per-channel enables.
- Sits between the SPI-side write ports and the downstream packet engine.

---
 rtl/stream_hub_if.sv | 33 +++
 rtl/stream_hub.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/stream_hub_if.sv
// stream_hub_if: the write ports, the packet output handshake and the status bus of stream_hub.
// Ports: in_data/in_valid/in_ready per channel, ch_en, out_data/out_ch/out_valid/out_done, ch_level, ovf.
// slave = the hub side, master = the producer/consumer side.
interface stream_hub_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PKT_LEN    = 8
);
  localparam int CW = $clog2(NUM_CH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0]            in_ready;
  logic [NUM_CH-1:0]            ch_en;
  logic [DATA_WIDTH*PKT_LEN-1:0] out_data;
  logic [CW-1:0]                out_ch;
  logic                         out_valid;
  logic                         out_done;
  logic [NUM_CH*LW-1:0]         ch_level;
  logic [NUM_CH-1:0]            ovf;

  modport slave (
    input  in_data, in_valid, ch_en, out_done,
    output in_ready, out_data, out_ch, out_valid, ch_level, ovf
  );

  modport master (
    output in_data, in_valid, ch_en, out_done,
    input  in_ready, out_data, out_ch, out_valid, ch_level, ovf
  );
endinterface

// File: rtl/stream_hub.sv
// stream_hub: NUM_CH word FIFOs, round-robin assembly of PKT_LEN-word packets for one packet consumer.
// Latency: eligible in IDLE -> out_valid high after 2+PKT_LEN cycles; out_valid holds until out_done.
// Backpressure: in_ready[c] low while FIFO c is full (write dropped, ovf[c] sticky); out_valid waits on out_done.
// Ports: clk, rst (sync, active-high), bus (stream_hub_if.slave).
// Option: define STREAM_HUB_PRIO_EN to give channel 0 strict priority over the round-robin of channels 1..NUM_CH-1.
module stream_hub #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PKT_LEN    = 8
) (
  input  logic          clk,
  input  logic          rst,
  stream_hub_if.slave   bus
);

  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int KW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int PW = DATA_WIDTH * PKT_LEN;

  localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PKT_LVL   = LW'(PKT_LEN);
  localparam logic [KW-1:0] LAST_K    = KW'(PKT_LEN - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [CW:0]   NCH_EXT   = (CW+1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, ARB, LOAD, SEND} state_t;

  // FIFO storage and state
  logic [DATA_WIDTH-1:0] r_mem   [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]         r_wptr  [NUM_CH];
  logic [AW-1:0]         r_rptr  [NUM_CH];
  logic [LW-1:0]         r_level [NUM_CH];
  logic [NUM_CH-1:0]     r_ovf;

  // Control / output registers
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_rr;
  logic [KW-1:0]         r_cnt;
  logic [CW-1:0]         r_out_ch;
  logic [PW-1:0]         r_out_data;
  logic                  r_out_valid;

  logic [NUM_CH-1:0]     w_ready;
  logic [NUM_CH-1:0]     w_push;
  logic [NUM_CH-1:0]     w_pop;
  logic [NUM_CH-1:0]     w_elig;
  logic [NUM_CH-1:0]     w_cand;
  logic [CW:0]           w_sum;
  logic [CW-1:0]         w_idx;
  logic [CW-1:0]         w_grant;
  logic                  w_grant_vld;
  logic [CW-1:0]         w_rr_nxt;
  logic [DATA_WIDTH-1:0] w_rd_word;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_ready[c] = (r_level[c] != DEPTH_LVL);
    assign w_push[c]  = bus.in_valid[c] & w_ready[c];
    // Only the granted channel is drained, one word per LOAD cycle.
    assign w_pop[c]   = (r_state == LOAD) && (r_out_ch == CW'(c));
    assign w_elig[c]  = bus.ch_en[c] && (r_level[c] >= PKT_LVL);
    assign bus.ch_level[c*LW +: LW] = r_level[c];
  end

  assign bus.in_ready  = w_ready;
  assign bus.ovf       = r_ovf;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;

  assign w_rd_word = r_mem[r_out_ch][r_rptr[r_out_ch]];

  // Storage is not reset: contents become unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wptr[c]] <= bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_level[c] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_pop[c])  r_rptr[c] <= r_rptr[c] + 1'b1;
        // Simultaneous push and pop leave the level unchanged.
        if (w_push[c] && !w_pop[c])      r_level[c] <= r_level[c] + 1'b1;
        else if (!w_push[c] && w_pop[c]) r_level[c] <= r_level[c] - 1'b1;
        if (bus.in_valid[c] && !w_ready[c]) r_ovf[c] <= 1'b1;
      end
    end
  end

  // Arbiter: first candidate at or above r_rr, wrapping modulo NUM_CH.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    w_cand      = w_elig;
`ifdef STREAM_HUB_PRIO_EN
    // Channel 0 bypasses the rotation; the others rotate among themselves.
    w_cand[0] = 1'b0;
    if (w_elig[0]) begin
      w_grant_vld = 1'b1;
      w_grant     = '0;
    end
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = {1'b0, r_rr} + (CW+1)'(i);
      if (w_sum >= NCH_EXT) w_sum = w_sum - NCH_EXT;
      w_idx = w_sum[CW-1:0];
      if (!w_grant_vld && w_cand[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx;
      end
    end
    w_rr_nxt = (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
`ifdef STREAM_HUB_PRIO_EN
    if (w_elig[0]) w_rr_nxt = r_rr;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_elig) w_state_nxt = ARB;
      // ch_en may drop between IDLE and ARB; fall back if nothing is left.
      ARB:     w_state_nxt = w_grant_vld ? LOAD : IDLE;
      LOAD:    if (r_cnt == LAST_K) w_state_nxt = SEND;
      SEND:    if (bus.out_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr        <= '0;
      r_cnt       <= '0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_grant_vld) begin
            r_out_ch <= w_grant;
            r_rr     <= w_rr_nxt;
            r_cnt    <= '0;
          end
        end
        LOAD: begin
          // Word k of the packet goes to slice k, oldest word in the LSBs.
          for (int k = 0; k < PKT_LEN; k++) begin
            if (r_cnt == KW'(k)) r_out_data[k*DATA_WIDTH +: DATA_WIDTH] <= w_rd_word;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_K) r_out_valid <= 1'b1;
        end
        SEND: begin
          if (bus.out_done) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
